apb_req_sched: RTL and testbench
================================

Name: apb_req_sched

Overview:
- Sequencer and round-robin arbiter that lets NUM_REQ internal requesters share one APB peripheral bus.
- Typical requesters: core debug path and SPI-slave-initiated accesses.
- Decodes the slave index from the request address and drives the standard two-phase APB transfer (SETUP, ACCESS).
- Optionally aborts hung slaves with a timeout. Sits between the requesters and the APB slaves (UART, GPIO, SPI master, timer, event unit, I2C, FLL, pad control).

Parameters:
- APB_ADDR_WIDTH, 12, offset width inside one slave window; paddr width.
- APB_NUM_SLAVES, 8, number of psel lines; must be at most 16.
- NUM_REQ, 2, number of requesters; must be at least 2.
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles without pready before abort; must be at least 1.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  NUM_REQ  request pending, one bit per requester.
- req_ready_o  out  NUM_REQ  one-cycle accept pulse, one-hot.
- req_addr_i  in  NUM_REQ x 32  byte address.
- req_write_i  in  NUM_REQ  1 = write.
- req_wdata_i  in  NUM_REQ x 32  write data.
- rsp_valid_o  out  NUM_REQ  one-cycle response pulse, one-hot, to the accepted requester.
- rsp_rdata_o  out  32  read data, valid with rsp_valid_o.
- rsp_err_o  out  1  error flag (pslverr, decode error or timeout), valid with rsp_valid_o.
- psel_o  out  APB_NUM_SLAVES  one-hot slave select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB write.
- paddr_o  out  APB_ADDR_WIDTH  APB address.
- pwdata_o  out  32  APB write data.
- prdata_i  in  APB_NUM_SLAVES x 32  per-slave read data.
- pready_i  in  APB_NUM_SLAVES  per-slave ready.
- pslverr_i  in  APB_NUM_SLAVES  per-slave error.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, timeout counter 0.
- Slave index = req_addr[APB_ADDR_WIDTH +: 4]; paddr = req_addr[APB_ADDR_WIDTH-1:0]. Bits above are ignored.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid_i is set, grant the first requester at or after the pointer (wrapping).
  - Assert req_ready_o[g] this cycle.
  - Latch addr, write, wdata and the grant index.
  - Move the pointer to g+1, wrapping at NUM_REQ.
  - If the slave index is >= APB_NUM_SLAVES, go to RESP with err=1 and rdata=0; no APB cycle is issued.
  - Otherwise go to SETUP.
- SETUP: psel_o[idx]=1, penable_o=0, paddr/pwrite/pwdata from the latch. Next state ACCESS.
- ACCESS:
  - psel_o[idx]=1, penable_o=1.
  - When pready_i[idx]=1: capture prdata_i[idx] (reads only, else 0) and pslverr_i[idx]. Go to RESP.
  - The timeout counter increments each ACCESS cycle without pready.
- RESP:
  - psel_o=0, penable_o=0.
  - rsp_valid_o[g]=1 for exactly one cycle, with rsp_rdata_o and rsp_err_o.
  - Next state IDLE; counter cleared.
- Latency: acceptance at cycle T gives SETUP at T+1, ACCESS at T+2, and with zero wait states rsp_valid_o at T+3. The next grant is no earlier than T+4. Each wait state adds 1 cycle.
- APB signals are stable from SETUP through the end of ACCESS.
- pready or pslverr from unselected slaves is ignored.
- A requester dropping req_valid_i before its grant is legal and loses nothing.
- Requester data does not need to be held after req_ready_o.
- Reset asserted mid-transfer: outputs go to reset values on the next edge. No response is issued for the in-flight request.

Optional Feature:
- Macro: APB_REQ_SCHED_TIMEOUT_EN.
- Defined: when the counter reaches TIMEOUT_CYCLES in ACCESS without pready, the transfer is aborted. Go to RESP with err=1 and rdata=0; psel/penable drop in RESP. A pready arriving in the same cycle the counter reaches the limit wins, giving a normal completion.
- Undefined: no counter is implemented; ACCESS waits indefinitely for pready.

Decomposition:
- Package apb_req_sched_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, RESP);
  - SLV_IDX_W = 4;
  - DATA_W = 32;
  - REQ_ADDR_W = 32.
- Sub-module apb_rr_arbiter (parameter NUM_REQ): inputs request vector, pointer and an update enable; outputs a one-hot grant and the grant index. It is purely combinational apart from the pointer register.

Test Plan:
- Req0 reads 0x0000_3004 while slave 3 holds pready=1 and prdata=0xDEAD_BEEF. Expect psel_o=0x08, paddr=0x004, penable at T+2, rsp_valid_o=01 at T+3, rdata=0xDEAD_BEEF, err=0.
- Req0 and req1 both hold valid requests for 4 transactions each. Expect grant order 0,1,0,1,...; no requester is granted twice in a row while the other is pending.
- Req1 writes 0x1234_5678 to 0x0000_1010; slave 1 holds pready low 3 cycles then raises it with pslverr=1. Expect ACCESS held 4 cycles, pwdata stable, rsp_valid_o=10, err=1.
- Req0 accesses 0x0000_A000 (index 10, 8 slaves). Expect no psel activity, rsp_valid_o at T+1, err=1, rdata=0.
- With APB_REQ_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=4, slave 5 never raises pready. Expect abort after 4 ACCESS cycles, err=1, psel_o=0, followed by normal service of the next request.
- Assert rst_i during ACCESS. Expect all outputs 0 on the next edge, no rsp_valid_o, pointer 0.

Source files
------------

// File: rtl/apb_req_sched_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : apb_req_sched_pkg
// Brief   : Shared state encoding and widths for the APB request scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
package apb_req_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int SLV_IDX_W  = 4;
    localparam int DATA_W     = 32;
    localparam int REQ_ADDR_W = 32;

endpackage
`default_nettype wire

// File: rtl/apb_req_sched_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : apb_req_sched_if
// Brief   : Requester-side and APB-side signals of the scheduler.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface apb_req_sched_if #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_NUM_SLAVES = 8,
    parameter int NUM_REQ        = 2
) ();
    import apb_req_sched_pkg::*;

    logic [NUM_REQ-1:0]                      req_valid_i;
    logic [NUM_REQ-1:0]                      req_ready_o;
    logic [NUM_REQ-1:0][REQ_ADDR_W-1:0]      req_addr_i;
    logic [NUM_REQ-1:0]                      req_write_i;
    logic [NUM_REQ-1:0][DATA_W-1:0]          req_wdata_i;
    logic [NUM_REQ-1:0]                      rsp_valid_o;
    logic [DATA_W-1:0]                       rsp_rdata_o;
    logic                                    rsp_err_o;

    logic [APB_NUM_SLAVES-1:0]               psel_o;
    logic                                    penable_o;
    logic                                    pwrite_o;
    logic [APB_ADDR_WIDTH-1:0]               paddr_o;
    logic [DATA_W-1:0]                       pwdata_o;
    logic [APB_NUM_SLAVES-1:0][DATA_W-1:0]   prdata_i;
    logic [APB_NUM_SLAVES-1:0]               pready_i;
    logic [APB_NUM_SLAVES-1:0]               pslverr_i;

    modport master (
        input  req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        input  prdata_i, pready_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_write_i, req_wdata_i,
        output prdata_i, pready_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, pwrite_o, paddr_o, pwdata_o
    );

endinterface
`default_nettype wire

// File: rtl/apb_rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : apb_rr_arbiter
// Brief   : Round-robin grant starting at the pointer; pointer moves past the winner.
// Revision: 1.0
// ---------------------------------------------------------------------------
module apb_rr_arbiter #(
    parameter int NUM_REQ = 2,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] gnt,
    output logic [PTR_W-1:0]   gnt_idx
);

    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(NUM_REQ - 1);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_cand = (int'(r_ptr) + i >= NUM_REQ) ? PTR_W'(int'(r_ptr) + i - NUM_REQ)
                                                  : PTR_W'(int'(r_ptr) + i);
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                gnt[w_cand]  = 1'b1;
                gnt_idx      = w_cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (update) begin
            r_ptr <= (gnt_idx == C_LAST) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_req_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : apb_req_sched
// Brief   : Round-robin sequencer sharing one APB bus between NUM_REQ requesters.
//           Define APB_REQ_SCHED_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES.
// Revision: 1.0
// ---------------------------------------------------------------------------
module apb_req_sched
    import apb_req_sched_pkg::*;
#(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int APB_NUM_SLAVES = 8,
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_i,
    apb_req_sched_if.master bus
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam logic [SLV_IDX_W:0] C_NUM_SLV = (SLV_IDX_W + 1)'(APB_NUM_SLAVES);

    state_t                    r_state;
    logic [NUM_REQ-1:0]        w_gnt;
    logic [PTR_W-1:0]          w_gnt_idx;
    logic [PTR_W-1:0]          r_gnt_idx;
    logic                      w_accept;
    logic [REQ_ADDR_W-1:0]     w_req_addr;
    logic [SLV_IDX_W-1:0]      w_req_slv;
    logic                      w_decode_err;
    logic [APB_NUM_SLAVES-1:0] r_psel;
    logic                      r_penable;
    logic                      r_pwrite;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_W-1:0]         r_pwdata;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [DATA_W-1:0]         r_rsp_rdata;
    logic                      r_rsp_err;
    logic                      w_sel_ready;
    logic                      w_sel_err;
    logic [DATA_W-1:0]         w_sel_rdata;
    logic                      w_tmo_hit;
    logic                      w_unused;

    // Gated by reset so nothing is accepted while the block is held in reset.
    assign w_accept = !rst_i && (r_state == IDLE) && (|bus.req_valid_i);

    apb_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk_i),
        .rst     (rst_i),
        .req     (bus.req_valid_i),
        .update  (w_accept),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    assign w_req_addr   = bus.req_addr_i[w_gnt_idx];
    assign w_req_slv    = w_req_addr[APB_ADDR_WIDTH +: SLV_IDX_W];
    assign w_decode_err = ({1'b0, w_req_slv} >= C_NUM_SLV);
    assign w_unused     = ^w_req_addr;

    // psel is one-hot, so masking with it ignores every unselected slave.
    always_comb begin
        w_sel_ready = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int s = 0; s < APB_NUM_SLAVES; s++) begin
            if (r_psel[s]) begin
                w_sel_ready = bus.pready_i[s];
                w_sel_err   = bus.pslverr_i[s];
                w_sel_rdata = bus.prdata_i[s];
            end
        end
    end

`ifdef APB_REQ_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    // The current stalled cycle is the one that brings the count to the limit.
    assign w_tmo_hit = (r_state == ACCESS) && (r_tmo_cnt == C_TMO_LAST);
`else
    localparam int C_UNUSED_TMO = TIMEOUT_CYCLES;

    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_gnt_idx   <= '0;
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_pwrite    <= 1'b0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
            r_rsp_valid <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
`ifdef APB_REQ_SCHED_TIMEOUT_EN
            r_tmo_cnt   <= '0;
`endif
        end else begin
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_gnt_idx <= w_gnt_idx;
                        if (w_decode_err) begin
                            r_rsp_valid <= w_gnt;
                            r_rsp_rdata <= '0;
                            r_rsp_err   <= 1'b1;
                            r_state     <= RESP;
                        end else begin
                            r_psel   <= APB_NUM_SLAVES'(1) << w_req_slv;
                            r_pwrite <= bus.req_write_i[w_gnt_idx];
                            r_paddr  <= w_req_addr[APB_ADDR_WIDTH-1:0];
                            r_pwdata <= bus.req_wdata_i[w_gnt_idx];
                            r_state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    r_penable <= 1'b1;
                    r_state   <= ACCESS;
                end
                ACCESS: begin
                    if (w_sel_ready || w_tmo_hit) begin
                        r_psel      <= '0;
                        r_penable   <= 1'b0;
                        r_rsp_valid <= NUM_REQ'(1) << r_gnt_idx;
                        r_rsp_rdata <= (w_sel_ready && !r_pwrite) ? w_sel_rdata : '0;
                        r_rsp_err   <= w_sel_ready ? w_sel_err : 1'b1;
                        r_state     <= RESP;
                    end
`ifdef APB_REQ_SCHED_TIMEOUT_EN
                    if (!w_sel_ready && !w_tmo_hit) begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    r_state <= IDLE;
`ifdef APB_REQ_SCHED_TIMEOUT_EN
                    r_tmo_cnt <= '0;
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o = w_accept ? w_gnt : '0;
    assign bus.rsp_valid_o = r_rsp_valid;
    assign bus.rsp_rdata_o = r_rsp_rdata;
    assign bus.rsp_err_o   = r_rsp_err;
    assign bus.psel_o      = r_psel;
    assign bus.penable_o   = r_penable;
    assign bus.pwrite_o    = r_pwrite;
    assign bus.paddr_o     = r_paddr;
    assign bus.pwdata_o    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_req_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_apb_req_sched
// Brief   : Randomized self-checking bench for apb_req_sched against a
//           transaction-level round-robin / APB model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_apb_req_sched;

    localparam int AW  = 12;
    localparam int NS  = 8;
    localparam int NR  = 2;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    apb_req_sched_if #(.APB_ADDR_WIDTH(AW), .APB_NUM_SLAVES(NS), .NUM_REQ(NR)) bus ();

    apb_req_sched #(
        .APB_ADDR_WIDTH (AW),
        .APB_NUM_SLAVES (NS),
        .NUM_REQ        (NR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Requester-side model: what each requester currently wants.
    logic        p_valid [NR];
    logic [31:0] p_addr  [NR];
    logic        p_write [NR];
    logic [31:0] p_wdata [NR];
    int          m_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_grant();
        for (int i = 0; i < NR; i++) begin
            if (p_valid[(m_ptr + i) % NR]) return (m_ptr + i) % NR;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic [31:0] a, input logic wr, input logic [31:0] wd);
        p_valid[i] = 1'b1;
        p_addr[i]  = a;
        p_write[i] = wr;
        p_wdata[i] = wd;
    endtask

    task automatic new_request(input int i);
        logic [31:0] a;
        a = $urandom();
        a[AW +: 4] = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        set_req(i, a, 1'($urandom_range(0, 1)), $urandom());
    endtask

    task automatic drive_reqs();
        for (int i = 0; i < NR; i++) begin
            bus.req_valid_i[i] = p_valid[i];
            bus.req_addr_i[i]  = p_addr[i];
            bus.req_write_i[i] = p_write[i];
            bus.req_wdata_i[i] = p_wdata[i];
        end
    endtask

    // Unselected slaves get random noise every cycle; it must be ignored.
    task automatic drive_slaves(input int sel, input logic rdy, input logic [31:0] rd, input logic err);
        for (int i = 0; i < NS; i++) begin
            bus.prdata_i[i]  = $urandom();
            bus.pready_i[i]  = 1'($urandom_range(0, 1));
            bus.pslverr_i[i] = 1'($urandom_range(0, 1));
        end
        if (sel >= 0) begin
            bus.pready_i[3'(sel)]  = rdy;
            bus.prdata_i[3'(sel)]  = rd;
            bus.pslverr_i[3'(sel)] = err;
        end
    endtask

    // One complete transaction, starting on the negedge of an IDLE cycle.
    task automatic run_txn(input int waits, input logic [31:0] rd, input logic serr);
        int          g, s, ncyc;
        logic [31:0] a, wd, exp_rd;
        logic        wr, abort, exp_err;
        @(negedge clk);
        drive_reqs();
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);
        g = model_grant();
        a  = p_addr[g];
        wr = p_write[g];
        wd = p_wdata[g];
        s  = int'(a[AW +: 4]);
        #1;
        check_val("accept_ready", 64'(bus.req_ready_o), 64'(1) << g);
        check_val("accept_psel", 64'(bus.psel_o), 64'h0);
        m_ptr = (g + 1) % NR;
        p_valid[g] = 1'b0;
        if ($urandom_range(0, 1) == 1) new_request(g);

        @(negedge clk);
        drive_reqs();
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);
        #1;
        if (s >= NS) begin
            check_val("decerr_rsp_valid", 64'(bus.rsp_valid_o), 64'(1) << g);
            check_val("decerr_err_rdata", 64'({bus.rsp_err_o, bus.rsp_rdata_o}), 64'({1'b1, 32'h0}));
            check_val("decerr_no_psel", 64'({bus.psel_o, bus.penable_o, bus.req_ready_o}), 64'h0);
            return;
        end
        check_val("setup_bus", 64'({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o}),
                  64'({NS'(32'd1 << s), 1'b0, wr, a[AW-1:0], wd}));
        check_val("setup_quiet", 64'({bus.rsp_valid_o, bus.req_ready_o}), 64'h0);

        abort = 1'b0;
        ncyc  = waits + 1;
`ifdef APB_REQ_SCHED_TIMEOUT_EN
        if (waits >= TMO) begin
            abort = 1'b1;
            ncyc  = TMO;
        end
`endif
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            drive_reqs();
            drive_slaves(s, !abort && (k == waits), rd, serr);
            #1;
            check_val("access_bus", 64'({bus.psel_o, bus.penable_o, bus.pwrite_o, bus.paddr_o, bus.pwdata_o}),
                      64'({NS'(32'd1 << s), 1'b1, wr, a[AW-1:0], wd}));
            check_val("access_quiet", 64'({bus.rsp_valid_o, bus.req_ready_o}), 64'h0);
        end

        @(negedge clk);
        drive_reqs();
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);
        #1;
        exp_rd  = (abort || wr) ? 32'h0 : rd;
        exp_err = abort ? 1'b1 : serr;
        check_val("resp_valid", 64'(bus.rsp_valid_o), 64'(1) << g);
        check_val("resp_rdata", 64'(bus.rsp_rdata_o), 64'(exp_rd));
        check_val("resp_err", 64'(bus.rsp_err_o), 64'(exp_err));
        check_val("resp_bus_idle", 64'({bus.psel_o, bus.penable_o, bus.req_ready_o}), 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int g;
        for (int i = 0; i < NR; i++) begin
            p_valid[i] = 1'b0;
            p_addr[i]  = '0;
            p_write[i] = 1'b0;
            p_wdata[i] = '0;
        end
        m_ptr = 0;
        drive_reqs();
        drive_slaves(-1, 1'b0, 32'h0, 1'b0);

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_val("reset_ctrl", 64'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o,
                                     bus.penable_o, bus.pwrite_o}), 64'h0);
        check_val("reset_data", 64'({bus.paddr_o, bus.pwdata_o}), 64'h0);
        check_val("reset_rdata", 64'(bus.rsp_rdata_o), 64'h0);
        rst = 1'b0;

        // Zero-wait read from slave 3
        set_req(0, 32'h0000_3004, 1'b0, 32'h0);
        run_txn(0, 32'hDEAD_BEEF, 1'b0);

        // Both requesters continuously pending: strict alternation
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) if (!p_valid[i]) new_request(i);
            run_txn($urandom_range(0, 2), $urandom(), 1'($urandom_range(0, 1)));
        end

        // Write with three wait states and a slave error
        p_valid[0] = 1'b0;
        set_req(1, 32'h0000_1010, 1'b1, 32'h1234_5678);
        run_txn(3, $urandom(), 1'b1);

        // Decode error: slave index 10
        p_valid[1] = 1'b0;
        set_req(0, 32'h0000_A000, 1'b0, 32'h0);
        run_txn(0, 32'h0, 1'b0);

        // Long stall on slave 5 (aborts when the timeout is built in), then normal service
        p_valid[1] = 1'b0;
        set_req(0, 32'h0000_5020, 1'b0, 32'h0);
        run_txn(20, 32'h5555_AAAA, 1'b0);
        set_req(1, 32'h0000_2008, 1'b0, 32'h0);
        run_txn(0, 32'hCAFE_F00D, 1'b0);

        // Reset in the middle of ACCESS
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        set_req(0, 32'h0000_2100, 1'b0, 32'h0);
        @(negedge clk);
        drive_reqs();
        drive_slaves(2, 1'b0, 32'h0, 1'b0);
        #1;
        g = model_grant();
        check_val("rst_pre_ready", 64'(bus.req_ready_o), 64'(1) << g);
        m_ptr = (g + 1) % NR;
        @(negedge clk);
        drive_slaves(2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        drive_slaves(2, 1'b0, 32'h0, 1'b0);
        #1;
        check_val("rst_pre_access", 64'({bus.psel_o, bus.penable_o}), 64'({NS'(8'h04), 1'b1}));
        new_request(0);
        new_request(1);
        drive_reqs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("rst_mid_ctrl", 64'({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_err_o, bus.psel_o,
                                       bus.penable_o, bus.pwrite_o}), 64'h0);
        check_val("rst_mid_data", 64'({bus.paddr_o, bus.pwdata_o}), 64'h0);
        m_ptr = 0;
        rst = 1'b0;
        bus.req_valid_i = '0;
        @(negedge clk);
        #1;
        check_val("rst_no_rsp", 64'(bus.rsp_valid_o), 64'h0);
        run_txn(0, $urandom(), 1'b0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!p_valid[i] && $urandom_range(0, 1) == 1) new_request(i);
                else if (p_valid[i] && $urandom_range(0, 7) == 0) p_valid[i] = 1'b0;
            end
            if (model_grant() < 0) new_request($urandom_range(0, NR - 1));
            run_txn($urandom_range(0, 6), $urandom(), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
